// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit for the execute path.
// One radix-2 step per clock: shift-add for MUL/MULHU, restoring division
// for DIVU/REMU. The result goes out on the register-file write port for a
// single WB cycle. Writes to R0 are suppressed, but done still pulses.
//
// Handshake: start is taken only on an edge where the FSM is IDLE. busy is
// high from the cycle after acceptance through the WB cycle. A start seen
// while busy is dropped, and the operands are not sampled again.
// write_enable is a one-cycle strobe, and WA/WD are valid only while it is
// high.
//
// The FSM state is kept in r_state (type state_t) so a checker can bind to it.
module muldiv_unit #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 3
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  operand_a,
   input  logic [WIDTH-1:0]  operand_b,
   input  logic [ADDR_W-1:0] dest_addr,
   output logic              busy,
   output logic              done,
   output logic              div_by_zero,
   output logic              write_enable,
   output logic [ADDR_W-1:0] WA,
   output logic [WIDTH-1:0]  WD
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;

   // Latched request
   logic [1:0]        r_op;
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic [ADDR_W-1:0] r_dest;
   logic              r_dbz;

   // Shared working registers:
   //   multiply: {r_hi, r_lo} is the 64-bit product, r_lo starts as the multiplier
   //   divide:   r_hi is the partial remainder, r_lo shifts dividend out / quotient in
   logic [WIDTH-1:0]  r_hi;
   logic [WIDTH-1:0]  r_lo;
   logic [CNT_W-1:0]  r_cnt;

   // Write-port registers, which hold their value between write-backs
   logic [ADDR_W-1:0] r_wa;
   logic [WIDTH-1:0]  r_wd;

   // Decode of the request presented on the inputs
   logic              w_zero_div;

   // One multiply step
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_prod_next;

   // One restoring-division step
   logic [WIDTH:0]     w_shift;
   logic               w_ge;
   logic [WIDTH-1:0]   w_sub;
   logic [WIDTH-1:0]   w_rem_next;
   logic [WIDTH-1:0]   w_quo_next;

   // Value written back after the final iteration
   logic [WIDTH-1:0]   w_result;

   assign w_zero_div = op[1] && (operand_b == '0);

   // Multiply step: add the multiplicand when the multiplier LSB is set, then shift right
   always_comb begin
      w_addend    = r_lo[0] ? r_a : '0;
      w_sum       = {1'b0, r_hi} + {1'b0, w_addend};
      w_prod_next = {w_sum, r_lo[WIDTH-1:1]};
   end

   // Divide step: shift in the next dividend bit, subtract the divisor if it fits
   always_comb begin
      w_shift    = {r_hi, r_lo[WIDTH-1]};
      w_ge       = (w_shift >= {1'b0, r_b});
      // When the divisor fits, the true difference is below 2^WIDTH, so truncating is exact
      w_sub      = w_shift[WIDTH-1:0] - r_b;
      w_rem_next = w_ge ? w_sub : w_shift[WIDTH-1:0];
      w_quo_next = {r_lo[WIDTH-2:0], w_ge};
   end

   // Pick the requested result from the values the last step produces
   always_comb begin
      w_result = '0;
      case (r_op)
         2'b00:   w_result = w_prod_next[WIDTH-1:0];
         2'b01:   w_result = w_prod_next[2*WIDTH-1:WIDTH];
         2'b10:   w_result = w_quo_next;
         default: w_result = w_rem_next;
      endcase
   end

   // FSM state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic: divide by zero skips RUN and goes straight to WB
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next_state = w_zero_div ? S_WB : S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == LAST_ITER) begin
               w_next_state = S_WB;
            end
         end
         S_WB:    w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs: busy through RUN and WB, strobes only in WB, no write to R0
   always_comb begin
      busy         = (r_state != S_IDLE);
      done         = (r_state == S_WB);
      div_by_zero  = (r_state == S_WB) && r_dbz;
      write_enable = (r_state == S_WB) && (r_dest != '0);
   end

   assign WA = r_wa;
   assign WD = r_wd;

   // Datapath: latch on acceptance, iterate in RUN, load the write port on entry to WB
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_op   <= '0;
         r_a    <= '0;
         r_b    <= '0;
         r_dest <= '0;
         r_dbz  <= 1'b0;
         r_hi   <= '0;
         r_lo   <= '0;
         r_cnt  <= '0;
         r_wa   <= '0;
         r_wd   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_op   <= op;
                  r_a    <= operand_a;
                  r_b    <= operand_b;
                  r_dest <= dest_addr;
                  r_dbz  <= w_zero_div;
                  r_cnt  <= '0;
                  r_hi   <= '0;
                  r_lo   <= op[1] ? operand_a : operand_b;
                  if (w_zero_div) begin
                     // Quotient is all ones and the remainder is the dividend
                     r_wa <= dest_addr;
                     r_wd <= op[0] ? operand_a : '1;
                  end
               end
            end
            S_RUN: begin
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_op[1]) begin
                  r_hi <= w_rem_next;
                  r_lo <= w_quo_next;
               end else begin
                  {r_hi, r_lo} <= w_prod_next;
               end
               if (r_cnt == LAST_ITER) begin
                  r_wa <= r_dest;
                  r_wd <= w_result;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed cases followed by random operations,
// checked against a plain-arithmetic reference model through a scoreboard queue.
module tb_muldiv_unit;

   localparam int W  = 32;
   localparam int AW = 3;

   logic          clk;
   logic          reset;
   logic          start;
   logic [1:0]    op;
   logic [W-1:0]  operand_a;
   logic [W-1:0]  operand_b;
   logic [AW-1:0] dest_addr;
   logic          busy;
   logic          done;
   logic          div_by_zero;
   logic          write_enable;
   logic [AW-1:0] WA;
   logic [W-1:0]  WD;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];

   muldiv_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
      .CLOCK_50     (clk),
      .reset        (reset),
      .start        (start),
      .op           (op),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .dest_addr    (dest_addr),
      .busy         (busy),
      .done         (done),
      .div_by_zero  (div_by_zero),
      .write_enable (write_enable),
      .WA           (WA),
      .WD           (WD)
   );

   // Clock and watchdog
   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: results straight from unsigned arithmetic
   function automatic logic [W-1:0] model_wd(input logic [1:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [63:0] p;
      p = {32'b0, a} * {32'b0, b};
      case (o)
         2'b00:   return p[31:0];
         2'b01:   return p[63:32];
         2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic drive_noise();
      start     = 1'($urandom_range(0, 1));
      op        = 2'($urandom_range(0, 3));
      operand_a = $urandom;
      operand_b = $urandom;
      dest_addr = 3'($urandom_range(0, 7));
   endtask

   // Issue one operation and follow it through write-back.
   // noise = 1 pulses start with junk operands during RUN and WB.
   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] d, input bit noise);
      int n;
      int lat;
      bit dz;
      logic [W-1:0] exp_wd;
      dz  = o[1] && (b == 0);
      lat = dz ? 1 : 33;
      exp_q.push_back(model_wd(o, a, b));
      start     = 1'b1;
      op        = o;
      operand_a = a;
      operand_b = b;
      dest_addr = d;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         check("busy_run", busy, 1);
         check("we_run", write_enable, 0);
         if (noise) drive_noise();
         @(negedge clk);
         n++;
      end
      check("latency", n, lat);
      if (exp_q.size() == 0) begin
         check("sb_empty", 1, 0);
         exp_wd = '0;
      end else begin
         exp_wd = exp_q.pop_front();
      end
      check("done", done, 1);
      check("busy_wb", busy, 1);
      check("we_wb", write_enable, (d != 0));
      check("dbz_wb", div_by_zero, dz);
      check("wa_wb", WA, d);
      check("wd_wb", WD, exp_wd);
      if (noise) begin
         drive_noise();
         start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      check("busy_after", busy, 0);
      check("done_after", done, 0);
      check("we_after", write_enable, 0);
      check("dbz_after", div_by_zero, 0);
      check("wa_hold", WA, d);
      check("wd_hold", WD, exp_wd);
   endtask

   // Stimulus, reset handling and final report
   initial begin
      int we_seen;
      logic [1:0] ro;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset     = 1'b1;
      start     = 1'b0;
      op        = '0;
      operand_a = '0;
      operand_b = '0;
      dest_addr = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dbz", div_by_zero, 0);
      check("rst_we", write_enable, 0);
      check("rst_wa", WA, 0);
      check("rst_wd", WD, 0);

      // Directed cases
      run_op(2'b00, 32'd7, 32'd6, 3'd3, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b0);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd5, 1'b0);
      run_op(2'b10, 32'd100, 32'd7, 3'd2, 1'b0);
      run_op(2'b11, 32'd100, 32'd7, 3'd2, 1'b0);
      run_op(2'b10, 32'h1234, 32'd0, 3'd4, 1'b0);
      run_op(2'b11, 32'h1234, 32'd0, 3'd4, 1'b0);

      // Reset during RUN: abort with no write-back
      start     = 1'b1;
      op        = 2'b00;
      operand_a = 32'd3;
      operand_b = 32'd5;
      dest_addr = 3'd1;
      @(negedge clk);
      start   = 1'b0;
      we_seen = 0;
      repeat (10) begin
         if (write_enable === 1'b1) we_seen++;
         @(negedge clk);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_wa", WA, 0);
      check("abort_wd", WD, 0);
      repeat (40) begin
         if (write_enable === 1'b1) we_seen++;
         @(negedge clk);
      end
      check("abort_no_write", we_seen, 0);
      check("abort_idle", busy, 0);
      run_op(2'b00, 32'd2, 32'd2, 3'd1, 1'b0);

      // Write to R0 with start pulsed while busy
      run_op(2'b00, 32'd3, 32'd3, 3'd0, 1'b1);
      we_seen = 0;
      repeat (5) begin
         if (busy === 1'b1) we_seen++;
         @(negedge clk);
      end
      check("no_second_op", we_seen, 0);

      // Random operations
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle unsigned multiply/divide unit in the execute path of the RISC CPU. It takes its operands from the register-file read ports RD1/RD2 and the destination register address from decode. When the operation completes it drives the register-file write port (write_enable/WA/WD) for one cycle. Decode uses busy to stall issue while an operation is in flight.

Parameters:
WIDTH, 32, operand and result width in bits
ADDR_W, 3, register address width (8 registers)

Ports:
CLOCK_50  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an operation; sampled only in IDLE
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder)
operand_a  input  WIDTH  multiplicand or dividend (from RD1)
operand_b  input  WIDTH  multiplier or divisor (from RD2)
dest_addr  input  ADDR_W  destination register for the result
busy  output  1  high while an accepted operation is in progress (RUN or WB)
done  output  1  one-cycle pulse in WB
div_by_zero  output  1  one-cycle pulse with done when DIVU or REMU had operand_b == 0
write_enable  output  1  register-file write strobe, one cycle in WB
WA  output  ADDR_W  register-file write address
WD  output  WIDTH  register-file write data

Behaviour:
- Reset is synchronous, active-high, and has priority over everything else. After the reset edge: state = IDLE; busy, done, div_by_zero, write_enable = 0; WA = 0; WD = 0.
- FSM states: IDLE, RUN, WB.
- IDLE: on an edge where start = 1, latch op, operand_a, operand_b and dest_addr, clear the 5-bit iteration counter, then go to RUN. The one exception is DIVU/REMU with operand_b == 0, which goes directly to WB.
- RUN: one iteration per edge; the counter counts 0..31. The edge that completes iteration 31 moves the FSM to WB.
  - MUL/MULHU: radix-2 shift-add into a 64-bit unsigned product.
  - DIVU/REMU: restoring division producing a 32-bit quotient and remainder.
- WB: lasts exactly one cycle, then returns to IDLE.
  - done = 1.
  - WD = selected result: product[31:0], product[63:32], quotient or remainder.
  - WA = latched dest_addr.
  - write_enable = 1 only if the latched dest_addr != 0. R0 is never written, but done still pulses.
- Latency: if start is accepted at edge E0, WB is the cycle after edge E32 (write_enable high for the 33rd cycle). For divide-by-zero, WB is the cycle after E0.
- Divide by zero: quotient = 0xFFFFFFFF; remainder = latched operand_a; div_by_zero = 1 during WB.
- busy = 1 in RUN and WB, 0 in IDLE. Decode must not issue a new operation while busy.
- start while busy (RUN or WB) is ignored; the in-flight operation and its latched operands are unaffected. A start in the WB cycle is also ignored, so the next acceptance is in IDLE.
- Inputs are don't-care outside the IDLE acceptance edge; operands are never re-sampled mid-operation.
- Reset mid-operation (RUN or WB): abort with no write-back; outputs take reset values on the next cycle.
- Outputs outside WB: done = div_by_zero = write_enable = 0. WA and WD hold their last driven values and are valid only while write_enable = 1.
- All arithmetic is unsigned modulo 2^32 except the 64-bit product.

Test Plan:
1. reset, then start op=00 a=7 b=6 dest=3 -> busy = 1 for 33 cycles; in the 33rd cycle write_enable = 1, WA = 3, WD = 42, done = 1, div_by_zero = 0; then busy = 0.
2. op=01 a=0xFFFFFFFF b=0xFFFFFFFF dest=5 -> WD = 0xFFFFFFFE. Repeat with op=00 -> WD = 0x00000001.
3. op=10 a=100 b=7 dest=2 -> WD = 14 after 33 cycles. op=11 with the same operands -> WD = 2.
4. op=10 a=0x1234 b=0 dest=4 -> WB in the cycle after acceptance, WD = 0xFFFFFFFF, div_by_zero = 1. op=11 with the same operands -> WD = 0x1234, div_by_zero = 1.
5. Start MUL a=3 b=5 dest=1; assert reset for one edge at RUN iteration 10 -> write_enable never asserts, busy = 0 after reset. A new MUL a=2 b=2 dest=1 is then accepted and writes WD = 4.
6. Start MUL a=3 b=3 dest=0; pulse start with a=9 b=9 dest=6 during RUN and again during WB -> a single done pulse, write_enable stays 0 (dest R0), and no second operation starts.
